// File: rtl/mt9v034_sync_decoder.sv
// mt9v034_sync_decoder
//   Decodes MT9V034 embedded sync codes from the deserialised 10-bit word
//   stream into an AXI4-Stream video stream (tuser = SOF, tlast = EOL).
//   The input has no back-pressure, so a FWFT FIFO absorbs output stalls.
//
//   Sync codes: 1023,0,1023 = FS, 1 = LS, 2 = LE, 3 = FE, 4 = blank.
//   Each pixel is held in a one-entry skid register until the next word
//   arrives, which tells us whether that pixel closes the line (tlast).
//
// Ports
//   aclk, aresetn        clock, async active-low reset
//   word, word_valid     decoded sensor words (no ready, gaps allowed)
//   m_axis_*             AXI4-Stream master (tdata, tvalid, tready, tuser, tlast)
//   err_clr              synchronous clear of the sticky error flags
//   err_ovf              sticky: FIFO overflow, pixel dropped
//   err_proto            sticky: sync sequence violation
//
// Build option
//   MT9V034_SYNC_STATS_EN adds frame_cnt, last_width, last_height outputs.
module mt9v034_sync_decoder #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 12
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [9:0]        word,
    input  logic              word_valid,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
    input  logic              err_clr,
    output logic              err_ovf,
    output logic              err_proto
`ifdef MT9V034_SYNC_STATS_EN
    ,
    output logic [31:0]       frame_cnt,
    output logic [CNT_W-1:0]  last_width,
    output logic [CNT_W-1:0]  last_height
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FS1   = 3'd1;
    localparam logic [2:0] S_FS2   = 3'd2;
    localparam logic [2:0] S_FRAME = 3'd3;
    localparam logic [2:0] S_LINE  = 3'd4;

    logic [2:0] state, state_nxt;
    logic       held_vld;
    logic [9:0] held_pix;
    logic       sof_pend;

    logic hold_ld, hold_clr, wr_req, wr_last, proto_err, sof_set;

    // ---------------------------------------------------------------
    // Sync decode
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        hold_ld   = 1'b0;
        hold_clr  = 1'b0;
        wr_req    = 1'b0;
        wr_last   = 1'b0;
        proto_err = 1'b0;
        sof_set   = 1'b0;
        if (word_valid) begin
            case (state)
                S_IDLE: if (word == 10'd1023) state_nxt = S_FS1;
                S_FS1: begin
                    if (word == 10'd0)         state_nxt = S_FS2;
                    else if (word == 10'd1023) state_nxt = S_FS1;
                    else                       state_nxt = S_IDLE;
                end
                S_FS2: begin
                    if (word == 10'd1023) begin
                        state_nxt = S_FRAME;
                        sof_set   = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
                S_FRAME: begin
                    case (word)
                        10'd1:         state_nxt = S_LINE;
                        10'd3:         state_nxt = S_IDLE;
                        10'd1023:      state_nxt = S_FS1;
                        10'd0, 10'd2:  proto_err = 1'b1;
                        default:       ;  // blanking and anything else
                    endcase
                end
                S_LINE: begin
                    case (word)
                        10'd2, 10'd3: begin
                            // Line end closes the held pixel; an empty line is a violation.
                            wr_req    = held_vld;
                            wr_last   = 1'b1;
                            proto_err = ~held_vld;
                            hold_clr  = 1'b1;
                            state_nxt = (word == 10'd2) ? S_FRAME : S_IDLE;
                        end
                        10'd1: begin
                            // Unexpected LS: drop the partial pixel and restart the line.
                            proto_err = 1'b1;
                            hold_clr  = 1'b1;
                        end
                        default: begin
                            wr_req  = held_vld;
                            hold_ld = 1'b1;
                        end
                    endcase
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= S_IDLE;
            held_vld <= 1'b0;
            held_pix <= '0;
            sof_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            if (hold_ld) begin
                held_vld <= 1'b1;
                held_pix <= word;
            end else if (hold_clr) begin
                held_vld <= 1'b0;
            end
            // SOF marks the first pixel offered to the FIFO, even if it is dropped.
            if (sof_set)     sof_pend <= 1'b1;
            else if (wr_req) sof_pend <= 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Output FIFO (first-word-fall-through); entry = {user, last, pixel}
    // ---------------------------------------------------------------
    logic [11:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          fifo_full, rd_en, wr_en, ovf_evt;
    logic [11:0]   rd_word;

    assign fifo_full = (count == (AW+1)'(FIFO_DEPTH));
    assign rd_en     = m_axis_tvalid & m_axis_tready;
    // A read in the same cycle frees a slot, so full+read+write is legal.
    assign wr_en     = wr_req & (~fifo_full | rd_en);
    assign ovf_evt   = wr_req & fifo_full & ~rd_en;

    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr] <= {sof_pend, wr_last, held_pix};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Outputs forced to zero while empty so nothing stale leaks out after reset.
    assign rd_word       = mem[rd_ptr];
    assign m_axis_tvalid = (count != '0);
    assign m_axis_tdata  = m_axis_tvalid ? DATA_W'(rd_word[9:0]) : '0;
    assign m_axis_tlast  = m_axis_tvalid & rd_word[10];
    assign m_axis_tuser  = m_axis_tvalid & rd_word[11];

    // ---------------------------------------------------------------
    // Sticky errors: a new event beats a simultaneous clear.
    // ---------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_ovf   <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            err_ovf   <= ovf_evt   | (err_ovf   & ~err_clr);
            err_proto <= proto_err | (err_proto & ~err_clr);
        end
    end

`ifdef MT9V034_SYNC_STATS_EN
    // ---------------------------------------------------------------
    // Frame statistics
    // ---------------------------------------------------------------
    logic [CNT_W-1:0] pix_cnt, line_cnt, line_w;
    logic             ls_evt, line_done, fe_evt;

    assign ls_evt    = word_valid & (word == 10'd1) & ((state == S_FRAME) | (state == S_LINE));
    assign line_done = word_valid & (state == S_LINE) & held_vld & ((word == 10'd2) | (word == 10'd3));
    assign fe_evt    = word_valid & (word == 10'd3) & ((state == S_FRAME) | (state == S_LINE));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pix_cnt     <= '0;
            line_cnt    <= '0;
            line_w      <= '0;
            frame_cnt   <= '0;
            last_width  <= '0;
            last_height <= '0;
        end else begin
            if (ls_evt)                      pix_cnt <= '0;
            else if (hold_ld && pix_cnt != '1) pix_cnt <= pix_cnt + 1'b1;

            if (sof_set)        line_cnt <= '0;
            else if (line_done) line_cnt <= line_cnt + 1'b1;

            if (line_done) line_w <= pix_cnt;

            if (fe_evt) begin
                frame_cnt <= frame_cnt + 1'b1;
                // FE may close a line itself or follow an LE from FRAME.
                if (line_done) begin
                    last_width  <= pix_cnt;
                    last_height <= line_cnt + 1'b1;
                end else begin
                    last_width  <= line_w;
                    last_height <= line_cnt;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_mt9v034_sync_decoder.sv
module tb_mt9v034_sync_decoder;

    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 12;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [9:0]        word;
    logic              word_valid;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tuser;
    logic              m_axis_tlast;
    logic              err_clr;
    logic              err_ovf;
    logic              err_proto;
`ifdef MT9V034_SYNC_STATS_EN
    logic [31:0]       frame_cnt;
    logic [CNT_W-1:0]  last_width;
    logic [CNT_W-1:0]  last_height;
`endif

    mt9v034_sync_decoder #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .word          (word),
        .word_valid    (word_valid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .err_clr       (err_clr),
        .err_ovf       (err_ovf),
        .err_proto     (err_proto)
`ifdef MT9V034_SYNC_STATS_EN
        ,
        .frame_cnt     (frame_cnt),
        .last_width    (last_width),
        .last_height   (last_height)
`endif
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [15:0] data;
        logic        user;
        logic        last;
    } beat_t;

    beat_t got[$];
    int    n_pass  = 0;
    int    n_total = 0;

    // Beats are sampled mid-cycle; inputs only change #1 after a rising edge.
    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            beat_t b;
            b.data = m_axis_tdata;
            b.user = m_axis_tuser;
            b.last = m_axis_tlast;
            got.push_back(b);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else             n_pass++;
    endtask

    task automatic send(input logic [9:0] w, input int gap);
        word       = w;
        word_valid = 1'b1;
        @(posedge aclk); #1;
        word_valid = 1'b0;
        repeat (gap) begin @(posedge aclk); #1; end
    endtask

    task automatic send_seq(input logic [9:0] ws[$], input int gap);
        foreach (ws[i]) send(ws[i], gap);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge aclk); #1; end
    endtask

    task automatic check_beats(input string nm, input beat_t exp[$]);
        chk({nm, " beat count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("%s beat %0d {user,last,data}", nm, i),
                {14'd0, got[i].user, got[i].last, got[i].data},
                {14'd0, exp[i].user, exp[i].last, exp[i].data});
    endtask

    function automatic beat_t mk(input int d, input logic u, input logic l);
        beat_t b;
        b.data = 16'(d);
        b.user = u;
        b.last = l;
        return b;
    endfunction

    initial begin
        logic [9:0] frame1[$];
        logic [9:0] long_frame[$];
        beat_t      exp1[$];
        beat_t      exp2[$];

        // Expected-vector tables
        frame1 = '{10'd1023, 10'd0, 10'd1023, 10'd1, 10'd10, 10'd11, 10'd12, 10'd13, 10'd2,
                   10'd1, 10'd20, 10'd21, 10'd22, 10'd23, 10'd3};
        exp1 = '{mk(10, 1, 0), mk(11, 0, 0), mk(12, 0, 0), mk(13, 0, 1),
                 mk(20, 0, 0), mk(21, 0, 0), mk(22, 0, 0), mk(23, 0, 1)};

        long_frame = '{10'd1023, 10'd0, 10'd1023, 10'd1};
        for (int p = 100; p < 120; p++) long_frame.push_back(10'(p));
        long_frame.push_back(10'd2);
        long_frame.push_back(10'd3);
        for (int p = 100; p < 100 + FIFO_DEPTH; p++) exp2.push_back(mk(p, p == 100, 0));

        aresetn       = 1'b0;
        word          = '0;
        word_valid    = 1'b0;
        m_axis_tready = 1'b1;
        err_clr       = 1'b0;

        // Reset state
        #3;
        chk("reset tvalid", m_axis_tvalid, 0);
        chk("reset tdata", m_axis_tdata, 0);
        chk("reset err_ovf", err_ovf, 0);
        chk("reset err_proto", err_proto, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        idle(2);

        // 1: basic frame
        send_seq(frame1, 0);
        idle(10);
        check_beats("t1", exp1);
        chk("t1 err_proto", err_proto, 0);
        chk("t1 err_ovf", err_ovf, 0);
`ifdef MT9V034_SYNC_STATS_EN
        chk("t1 frame_cnt", frame_cnt, 1);
        chk("t1 last_width", 32'(last_width), 4);
        chk("t1 last_height", 32'(last_height), 2);
`endif

        // 2: overflow with stalled sink
        got.delete();
        m_axis_tready = 1'b0;
        send_seq(long_frame, 0);
        idle(3);
        chk("t2 err_ovf set", err_ovf, 1);
        chk("t2 tvalid held", m_axis_tvalid, 1);
        chk("t2 tdata stable while stalled", m_axis_tdata, 100);
        chk("t2 no beats while stalled", got.size(), 0);
        m_axis_tready = 1'b1;
        idle(FIFO_DEPTH + 5);
        check_beats("t2", exp2);
        chk("t2 drained", m_axis_tvalid, 0);
        err_clr = 1'b1; idle(1); err_clr = 1'b0;
        chk("t2 err_ovf cleared", err_ovf, 0);

        // 3: partial FS then LS is ignored; a full frame decodes afterwards
        got.delete();
        send_seq('{10'd1023, 10'd0, 10'd5, 10'd1, 10'd30, 10'd31, 10'd2}, 0);
        idle(5);
        chk("t3 no output", got.size(), 0);
        chk("t3 err_proto", err_proto, 0);
        send_seq(frame1, 0);
        idle(10);
        check_beats("t3", exp1);

        // 4: empty line, then error set coinciding with clear
        got.delete();
        send_seq('{10'd1023, 10'd0, 10'd1023, 10'd1, 10'd2}, 0);
        idle(5);
        chk("t4 err_proto set", err_proto, 1);
        chk("t4 no beat", got.size(), 0);
        err_clr = 1'b1; idle(1); err_clr = 1'b0;
        chk("t4 err_proto cleared", err_proto, 0);
        send(10'd1, 0);
        err_clr = 1'b1;
        send(10'd2, 0);
        err_clr = 1'b0;
        chk("t4 error wins over clear", err_proto, 1);
        send(10'd3, 0);
        err_clr = 1'b1; idle(1); err_clr = 1'b0;
        chk("t4 err_proto cleared again", err_proto, 0);

        // 5: reset mid-line
        got.delete();
        m_axis_tready = 1'b0;
        send_seq('{10'd1023, 10'd0, 10'd1023, 10'd1, 10'd50, 10'd51}, 0);
        idle(2);
        chk("t5 pixel queued before reset", m_axis_tvalid, 1);
        aresetn = 1'b0;
        #2;
        chk("t5 tvalid in reset", m_axis_tvalid, 0);
        chk("t5 tdata in reset", m_axis_tdata, 0);
        idle(2);
        aresetn       = 1'b1;
        m_axis_tready = 1'b1;
        idle(3);
        chk("t5 fifo empty after reset", m_axis_tvalid, 0);
        chk("t5 nothing stale", got.size(), 0);
        send_seq(frame1, 0);
        idle(10);
        check_beats("t5", exp1);

        // 6: three idle cycles between every word
        got.delete();
        send_seq(frame1, 3);
        idle(10);
        check_beats("t6", exp1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard stop in case a wait ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
